// File: rtl/mc_read_streamer_if.sv
// MC read port plus the response stream toward the datapath.
interface mc_read_streamer_if;
  logic        mc_req_ld;
  logic [47:0] mc_req_vadr;
  logic        mc_rd_rq_stall;
  logic        mc_rsp_push;
  logic        mc_rsp_stall;
  logic [63:0] mc_rsp_data;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;

  // Streamer side: issues requests, receives responses, sources the stream.
  modport master (
    output mc_req_ld, mc_req_vadr, mc_rsp_stall, out_valid, out_data,
    input  mc_rd_rq_stall, mc_rsp_push, mc_rsp_data, out_ready
  );

  // Memory controller / consumer side.
  modport slave (
    input  mc_req_ld, mc_req_vadr, mc_rsp_stall, out_valid, out_data,
    output mc_rd_rq_stall, mc_rsp_push, mc_rsp_data, out_ready
  );
endinterface

// File: rtl/mc_read_streamer.sv
// Read-port initiator: turns (base, count) into 64-bit loads, buffers the
// in-order responses in a credit-protected FIFO and streams them out.
module mc_read_streamer #(
  parameter int unsigned FIFO_DEPTH       = 16,
  parameter int unsigned RSP_STALL_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [47:0]          base_vadr,
  input  logic [31:0]          word_count,
  output logic                 busy,
  output logic                 done,
  mc_read_streamer_if.master   mc
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [47:0]   base_q, base_d;
  logic [31:0]   wc_q, wc_d;
  logic [31:0]   issued_q, issued_d;
  logic [31:0]   rsp_cnt_q, rsp_cnt_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic          req_ld_q, req_ld_d;
  logic [47:0]   req_vadr_q, req_vadr_d;
  logic          rsp_stall_q, rsp_stall_d;
  logic          out_valid_q, out_valid_d;
  logic [63:0]   out_data_q, out_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_spurious_q, err_spurious_d;

  logic          push_c, pop_c, issue_c;
  logic [CW-1:0] credit_c, left_c;

  // Next-state, counters, FIFO bookkeeping and registered outputs.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    wc_d           = wc_q;
    issued_d       = issued_q;
    req_ld_d       = 1'b0;
    req_vadr_d     = req_vadr_q;
    err_spurious_d = err_spurious_q;

    pop_c    = out_valid_q & mc.out_ready;
    push_c   = mc.mc_rsp_push & ((state_q == ISSUE) | (state_q == DRAIN)) & (outst_q != '0);
    credit_c = CW'(FIFO_DEPTH) - occ_q - outst_q;
    issue_c  = (state_q == ISSUE) & ~mc.mc_rd_rq_stall & (issued_q != wc_q) & (credit_c != '0);

    err_spurious_d = err_spurious_q | (mc.mc_rsp_push & ~push_c);
    rsp_cnt_d      = rsp_cnt_q + 32'(push_c);
    outst_d        = outst_q + CW'(issue_c) - CW'(push_c);
    occ_d          = occ_q + CW'(push_c) - CW'(pop_c);
    wr_ptr_d       = wr_ptr_q + AW'(push_c);
    rd_ptr_d       = rd_ptr_q + AW'(pop_c);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_vadr & ~48'h7;
          wc_d      = word_count;
          issued_d  = '0;
          rsp_cnt_d = '0;
          state_d   = (word_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_c) begin
          req_ld_d   = 1'b1;
          req_vadr_d = base_q + 48'({issued_q, 3'b000});
          issued_d   = issued_q + 32'd1;
          if (32'(issued_q + 32'd1) == wc_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((rsp_cnt_q == wc_q) && (occ_q == '0)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // First-word fall-through head, kept registered.
    left_c = occ_q - CW'(pop_c);
    if (left_c != '0)  out_data_d = mem_q[rd_ptr_d];
    else if (push_c)   out_data_d = mc.mc_rsp_data;
    else               out_data_d = '0;

    out_valid_d = (occ_d != '0);
    rsp_stall_d = (CW'(FIFO_DEPTH) - occ_d - outst_d) <= CW'(RSP_STALL_MARGIN);
    busy_d      = (state_d == ISSUE) | (state_d == DRAIN);
    done_d      = (state_d == DONE);
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      base_q         <= '0;
      wc_q           <= '0;
      issued_q       <= '0;
      rsp_cnt_q      <= '0;
      occ_q          <= '0;
      outst_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      req_ld_q       <= 1'b0;
      req_vadr_q     <= '0;
      rsp_stall_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      wc_q           <= wc_d;
      issued_q       <= issued_d;
      rsp_cnt_q      <= rsp_cnt_d;
      occ_q          <= occ_d;
      outst_q        <= outst_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      req_ld_q       <= req_ld_d;
      req_vadr_q     <= req_vadr_d;
      rsp_stall_q    <= rsp_stall_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  // Response storage; pointers and occupancy above decide what is live.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= mc.mc_rsp_data;
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign mc.mc_req_ld    = req_ld_q;
  assign mc.mc_req_vadr  = req_vadr_q;
  assign mc.mc_rsp_stall = rsp_stall_q;
  assign mc.out_valid    = out_valid_q;
  assign mc.out_data     = out_data_q;
endmodule

// File: tb/tb_mc_read_streamer.sv
// Bench for mc_read_streamer: table-driven commands, hand-written corner
// sequences and random commands, all checked against a count-based model.
module tb_mc_read_streamer;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned MARGIN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [47:0] base_vadr;
  logic [31:0] word_count;
  logic        busy;
  logic        done;

  mc_read_streamer_if bus();

  mc_read_streamer #(.FIFO_DEPTH(DEPTH), .RSP_STALL_MARGIN(MARGIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_vadr  (base_vadr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .mc         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] base;
    int unsigned count;
    int unsigned stall_pct;
    int unsigned ready_pct;
    int unsigned lat;
    int unsigned exp_reqs;
    logic [47:0] exp_last;
  } vec_t;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  // Model: a command is a sequence of words base+8*i; everything else is counts.
  logic [47:0] m_base;
  int unsigned m_count;
  logic [15:0] m_salt;
  int unsigned n_req, n_pop, n_push, cyc, done_cnt, done_cyc, start_cyc;
  int unsigned last_pop_cyc, first_req_cyc, last_req_cyc, gaps;
  logic [47:0] last_addr;
  int unsigned stall_pct, ready_pct, lat, stall_win_at, stall_win_left;
  bit          prev_stall;
  logic [63:0] pend_data[$];
  int unsigned pend_due[$];
  bit          pend_live[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle at the falling edge: check outputs, then drive next inputs.
  task automatic step();
    logic        rdy;
    logic        stl;
    logic [47:0] ea;
    if (bus.mc_req_ld) begin
      ea = m_base + (48'(n_req) << 3);
      chk("req_addr", 64'(bus.mc_req_vadr), 64'(ea));
      chk("req_in_cmd", 64'(n_req < m_count), 64'd1);
      if (n_req == 0) first_req_cyc = cyc;
      else if (cyc != last_req_cyc + 1) gaps++;
      last_req_cyc = cyc;
      last_addr    = bus.mc_req_vadr;
      n_req++;
      chk("credit", 64'((n_req - n_pop) <= DEPTH), 64'd1);
      pend_data.push_back({m_salt, bus.mc_req_vadr});
      pend_due.push_back(cyc + lat);
      pend_live.push_back(1'b1);
    end
    if (prev_stall) chk("stall_gap", 64'(bus.mc_req_ld), 64'd0);
    chk("rsp_stall", 64'(bus.mc_rsp_stall), 64'((DEPTH - (n_req - n_pop)) <= MARGIN));
    chk("out_valid", 64'(bus.out_valid), 64'(n_push > n_pop));
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end

    rdy = ($urandom_range(99) < ready_pct);
    bus.out_ready = rdy;
    if (bus.out_valid && rdy) begin
      chk("out_data", bus.out_data, {m_salt, m_base + (48'(n_pop) << 3)});
      n_pop++;
      last_pop_cyc = cyc;
    end

    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      bus.mc_rsp_push = 1'b1;
      bus.mc_rsp_data = pend_data[0];
      if (pend_live[0]) n_push++;
      void'(pend_data.pop_front());
      void'(pend_due.pop_front());
      void'(pend_live.pop_front());
    end else begin
      bus.mc_rsp_push = 1'b0;
      bus.mc_rsp_data = {$urandom, $urandom};
    end

    stl = ($urandom_range(99) < stall_pct);
    if (stall_win_left > 0 && n_req >= stall_win_at) begin
      stl = 1'b1;
      stall_win_left--;
    end
    bus.mc_rd_rq_stall = stl;
    prev_stall = stl;
    cyc++;
    @(negedge clk);
  endtask

  task automatic begin_cmd(input logic [47:0] b, input int unsigned cnt, input int unsigned sp,
                           input int unsigned rp, input int unsigned l, input logic [15:0] salt);
    m_base    = b & 48'hFFFF_FFFF_FFF8;
    m_count   = cnt;
    m_salt    = salt;
    n_req     = 0;
    n_pop     = 0;
    n_push    = 0;
    done_cnt  = 0;
    gaps      = 0;
    last_addr = '0;
    stall_pct = sp;
    ready_pct = rp;
    lat       = l;
    start      = 1'b1;
    base_vadr  = b;
    word_count = cnt;
    start_cyc  = cyc;
    step();
    start      = 1'b0;
    base_vadr  = 48'($urandom);
    word_count = $urandom;
    chk("busy_after_start", 64'(busy), 64'(cnt != 0));
  endtask

  task automatic finish_cmd(input int unsigned exp_reqs, input logic [47:0] exp_last);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
    chk("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (3) step();
    chk("req_count", 64'(n_req), 64'(exp_reqs));
    chk("pop_count", 64'(n_pop), 64'(m_count));
    chk("last_addr", 64'(last_addr), 64'(exp_last));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
    if (m_count != 0) chk("done_latency", 64'(done_cyc - last_pop_cyc), 64'd2);
    else              chk("done_latency", 64'(done_cyc - start_cyc), 64'd1);
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req_ld", 64'(bus.mc_req_ld), 64'd0);
    chk("rst_req_vadr", 64'(bus.mc_req_vadr), 64'd0);
    chk("rst_rsp_stall", 64'(bus.mc_rsp_stall), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{48'h0000_0000_1000,  4,  0, 100, 3,  4, 48'h0000_0000_1018};
    vecs[1] = '{48'hFFFF_FFFF_FFF8,  2,  0, 100, 2,  2, 48'h0000_0000_0000};
    vecs[2] = '{48'h0000_0000_5000,  0,  0, 100, 2,  0, 48'h0000_0000_0000};
    vecs[3] = '{48'h0000_0000_2007,  5, 20,  60, 4,  5, 48'h0000_0000_2020};
    vecs[4] = '{48'h0000_0000_ABC0, 17, 10,  50, 5, 17, 48'h0000_0000_AC40};

    rst = 1'b1; start = 1'b0; base_vadr = '0; word_count = '0;
    bus.mc_rd_rq_stall = 1'b0; bus.mc_rsp_push = 1'b0; bus.mc_rsp_data = '0; bus.out_ready = 1'b0;
    m_base = '0; m_count = 0; m_salt = '0; n_req = 0; n_pop = 0; n_push = 0; cyc = 0;
    done_cnt = 0; done_cyc = 0; start_cyc = 0; last_pop_cyc = 0; first_req_cyc = 0;
    last_req_cyc = 0; gaps = 0; last_addr = '0; stall_pct = 0; ready_pct = 100; lat = 2;
    stall_win_at = 0; stall_win_left = 0; prev_stall = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    step();

    // Table of commands with hand-computed request counts and final addresses.
    for (int v = 0; v < 5; v++) begin
      begin_cmd(vecs[v].base, vecs[v].count, vecs[v].stall_pct, vecs[v].ready_pct,
                vecs[v].lat, (v == 0) ? 16'h0 : 16'(v * 16'h1111));
      finish_cmd(vecs[v].exp_reqs, vecs[v].exp_last);
      if (vecs[v].stall_pct == 0 && vecs[v].count != 0) begin
        chk("first_req_latency", 64'(first_req_cyc - start_cyc), 64'd2);
        chk("back_to_back", 64'(gaps), 64'd0);
      end
    end

    // Five-cycle request stall in the middle of an 8-word command.
    stall_win_at = 3; stall_win_left = 5;
    begin_cmd(48'h2_0000, 8, 0, 100, 3, 16'h7777);
    finish_cmd(8, 48'h2_0038);
    chk("stall_window_gap", 64'(gaps != 0), 64'd1);
    stall_win_left = 0;

    // Credit limit: consumer stalled, issue must stop at FIFO_DEPTH.
    begin_cmd(48'h1_0000, 40, 0, 0, 2, 16'hC0DE);
    repeat (60) step();
    chk("credit_stop", 64'(n_req), 64'(DEPTH));
    chk("credit_rsp_stall", 64'(bus.mc_rsp_stall), 64'd1);
    ready_pct = 100;
    finish_cmd(40, 48'h1_0138);

    // Second start while busy must not disturb the running command.
    begin_cmd(48'h8000, 6, 0, 100, 3, 16'h0BAD);
    step(); step();
    start = 1'b1; base_vadr = 48'h9000; word_count = 100;
    step();
    start = 1'b0;
    finish_cmd(6, 48'h8028);

    // Reset with five requests outstanding; late responses are dropped.
    begin_cmd(48'h4000, 20, 0, 0, 25, 16'hDEAD);
    for (int i = 0; i < 50 && n_req < 5; i++) step();
    chk("reset_prereq", 64'(n_req), 64'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < pend_live.size(); i++) pend_live[i] = 1'b0;
    m_count = 0; n_req = 0; n_pop = 0; n_push = 0; done_cnt = 0; prev_stall = 1'b0;
    check_reset_vals();
    ready_pct = 100;
    repeat (40) step();
    chk("reset_no_done", 64'(done_cnt), 64'd0);
    chk("reset_drained", 64'(pend_due.size()), 64'd0);
    begin_cmd(48'h3_0000, 3, 0, 100, 2, 16'h3333);
    finish_cmd(3, 48'h3_0010);

    // Random commands.
    for (int r = 0; r < 8; r++) begin
      logic [47:0] rb;
      int unsigned rc;
      rb = {16'($urandom), $urandom};
      rc = $urandom_range(30, 1);
      begin_cmd(rb, rc, $urandom_range(40), $urandom_range(100, 30), $urandom_range(6, 1),
                16'($urandom));
      finish_cmd(rc, (rb & 48'hFFFF_FFFF_FFF8) + (48'(rc - 1) << 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mc_read_streamer.md
# mc_read_streamer

Initiator for one memory-controller read port. It turns a (base address, word count) command into a stream of 64-bit load requests, collects the in-order responses into an internal FIFO, and presents them to the datapath on a valid/ready interface. It sits between shepard's read/hash/compare datapath and an MC read port (mc_req_ld / mc_req_vadr / mc_rd_rq_stall / mc_rsp_push / mc_rsp_stall / mc_rsp_data). It is the requesting end of the port that the system bench answers.

## Interface
Parameters:
- FIFO_DEPTH, 16: response FIFO entries. Power of two, at least 4.
- RSP_STALL_MARGIN, 2: mc_rsp_stall asserts when free FIFO entries are at or below this value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_vadr  in  48  byte address of word 0; captured on accepted start; bits [2:0] ignored (treated as 0).
- word_count  in  32  number of 64-bit words; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- mc_req_ld  out  1  load request; every asserted cycle is one accepted request.
- mc_req_vadr  out  48  request address; valid while mc_req_ld=1.
- mc_rd_rq_stall  in  1  MC back-pressure on requests.
- mc_rsp_push  in  1  response valid; always accepted.
- mc_rsp_stall  out  1  advisory back-pressure to the MC.
- mc_rsp_data  in  64  response data.
- out_valid  out  1  FIFO non-empty.
- out_data  out  64  FIFO head (first-word fall-through).
- out_ready  in  1  consumer pop; a pop occurs when out_valid and out_ready are both high.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, on start: latch base and count, clear the issue and response counters, go to ISSUE. If count=0, go to DONE instead. start is ignored in every other state.
- ISSUE:
  - The registered mc_req_ld is driven high for the next cycle when all three hold at the current edge: mc_rd_rq_stall=0, remaining>0, credit>0.
  - Address of request i is base + 8*i. The arithmetic is modulo 2^48; wrap is silent.
  - Move to DRAIN on the edge that registers the final request.
- Credit accounting:
  - credit = FIFO_DEPTH − fifo_occupancy − outstanding.
  - outstanding increments on each issued request and decrements on each mc_rsp_push; both in one cycle leave it unchanged.
  - Credit guarantees the FIFO never overflows.
- Responses arrive in request order. Each mc_rsp_push writes mc_rsp_data to the FIFO tail and increments rsp_count.
- DRAIN: wait until rsp_count equals word_count and the FIFO is empty, then go to DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- mc_rsp_stall = (FIFO_DEPTH − occupancy − outstanding) ≤ RSP_STALL_MARGIN. It is registered.
- A mc_rsp_push while IDLE or DONE is dropped and sets the sticky debug bit err_spurious (internal). A push with outstanding=0 is dropped in the same way.
- Simultaneous push and pop on the same edge: occupancy is unchanged; a full FIFO still accepts the push.

## Timing
- Reset values: busy=0, done=0, mc_req_ld=0, mc_req_vadr=0, mc_rsp_stall=0, out_valid=0, out_data=0. The FIFO and all counters are cleared and the state is IDLE.
- Reset mid-command aborts immediately. Responses still in flight from the aborted command are dropped per the IDLE rule.
- Start accepted at edge N: busy=1 after N. The earliest mc_req_ld is during cycle N+1→N+2.
- Sustained issue rate is 1 request per cycle while unstalled and with credit.
- mc_rd_rq_stall high at edge E means mc_req_ld=0 in the cycle following E.
- A response pushed at edge E gives out_valid=1 after E, with out_data equal to that word.
- done is asserted on the edge after the final pop, so the earliest done is 1 cycle after the last pop.

## Test plan
- Basic stream:
  - Stimulus: base=0x1000, count=4; responder returns data equal to address after 3 cycles; out_ready=1.
  - Required: requests at 0x1000, 0x1008, 0x1010, 0x1018 in consecutive cycles; out_data sequence 0x1000..0x1018; exactly one done pulse.
- Request stall:
  - Stimulus: count=8; hold mc_rd_rq_stall=1 for 5 cycles mid-stream.
  - Required: no mc_req_ld in the cycle after each stalled edge; exactly 8 requests; addresses contiguous with no gaps or repeats.
- Credit limit:
  - Stimulus: FIFO_DEPTH=16, count=40, out_ready=0, responder returns everything.
  - Required: issue stops at 16 requests; mc_rsp_stall=1 once credit ≤2; raising out_ready resumes issue; all 40 words delivered in order.
- Zero and wrap:
  - Zero stimulus: count=0. Required: done pulse one cycle after start, no mc_req_ld.
  - Wrap stimulus: base=0xFFFF_FFFF_FFF8, count=2. Required: addresses 0xFFFF_FFFF_FFF8 then 0x0.
- Reset mid-op:
  - Stimulus: assert rst with 5 requests outstanding, then push their responses after reset.
  - Required: all outputs return to reset values; pushes dropped; out_valid stays 0; a new command with count=3 completes normally.
- Ignored start:
  - Stimulus: second start while busy.
  - Required: the second start is ignored; the word count of the first command is unaffected.
